train_led_encoder: RTL and testbench

//   Serial bit-stream generator for the TrainLED2 chain; sits directly upstream of the

---
 rtl/train_led_encoder_if.sv | 22 ++
 rtl/train_led_encoder.sv | 121 ++++++++++++
 tb/tb_train_led_encoder.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/train_led_encoder_if.sv
// Pixel handshake, latch request and serial output bundle for the TrainLED2 encoder.
// master = pixel source side, slave = encoder side.
interface train_led_encoder_if #(
   parameter int unsigned BITS = 24
) ();
   logic [BITS-1:0] pixel_data;
   logic            pixel_valid;
   logic            pixel_ready;
   logic            latch_req;
   logic            dout;
   logic            busy;

   modport master (
      output pixel_data, pixel_valid, latch_req,
      input  pixel_ready, dout, busy
   );

   modport slave (
      input  pixel_data, pixel_valid, latch_req,
      output pixel_ready, dout, busy
   );
endinterface

// File: rtl/train_led_encoder.sv
// TrainLED2 serial stream generator: shifts pixel words out MSB-first as
// pulse-width-coded bits and inserts low latch gaps on request.
module train_led_encoder #(
   parameter int unsigned BITS   = 24,
   parameter int unsigned T0H    = 4,
   parameter int unsigned T1H    = 8,
   parameter int unsigned TBIT   = 12,
   parameter int unsigned TRESET = 500
) (
   input logic               clk,
   input logic               rst,
   train_led_encoder_if.slave bus
);
   localparam int unsigned CW = $clog2(TBIT);
   localparam int unsigned IW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int unsigned LW = $clog2(TRESET);

   typedef enum logic [1:0] {S_IDLE, S_BIT, S_LATCH} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [BITS-1:0] shreg_q, shreg_d;
   logic [LW-1:0]   lcnt_q, lcnt_d;
   logic            pend_q, pend_d;
   logic            dout_q, dout_d;

   logic            last_bit, bit_end, gap_end, ready, xfer, pend_any;
   logic [CW-1:0]   thigh;

   assign last_bit = (idx_q == IW'(BITS - 1));
   assign bit_end  = (cnt_q == CW'(TBIT - 1));
   assign gap_end  = (lcnt_q == LW'(TRESET - 1));
   assign ready    = ((state_q == S_IDLE) && !pend_q) ||
                     ((state_q == S_BIT) && last_bit && bit_end);
   assign xfer     = bus.pixel_valid && ready;
   assign pend_any = pend_q || bus.latch_req;
   assign thigh    = shreg_q[BITS-1] ? CW'(T1H) : CW'(T0H);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      lcnt_d  = lcnt_q;
      pend_d  = pend_any;
      // dout lags the bit state by one cycle: a transfer at edge k drives high from k+1
      dout_d  = (state_q == S_BIT) && (cnt_q < thigh);

      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_d = S_LATCH;
               lcnt_d  = '0;
               pend_d  = 1'b0;
            end else if (xfer) begin
               state_d = S_BIT;
               shreg_d = bus.pixel_data;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         S_BIT: begin
            if (!bit_end) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (!last_bit) begin
                  shreg_d = {shreg_q[BITS-2:0], 1'b0};
                  idx_d   = idx_q + 1'b1;
               end else if (xfer) begin
                  shreg_d = bus.pixel_data;
                  idx_d   = '0;
               end else if (pend_any) begin
                  state_d = S_LATCH;
                  lcnt_d  = '0;
                  pend_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_LATCH: begin
            if (!gap_end) begin
               lcnt_d = lcnt_q + 1'b1;
            end else if (pend_any) begin
               // a request seen during the gap chains a second gap with no idle cycle
               lcnt_d = '0;
               pend_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         lcnt_q  <= '0;
         pend_q  <= 1'b0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         lcnt_q  <= lcnt_d;
         pend_q  <= pend_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.pixel_ready = ready;
   assign bus.dout        = dout_q;
   assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_train_led_encoder.sv
// Self-checking bench for train_led_encoder: directed timing scenarios plus a
// randomized run decoded back into words from the recorded dout pulse widths.
module tb_train_led_encoder;
   localparam int unsigned BITS   = 24;
   localparam int unsigned T0H    = 4;
   localparam int unsigned T1H    = 8;
   localparam int unsigned TBIT   = 12;
   localparam int unsigned TRESET = 500;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   train_led_encoder_if #(.BITS(BITS)) bus ();

   train_led_encoder #(
      .BITS(BITS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // cycle trace sampled on the falling edge
   logic dq[$];
   logic bq[$];
   bit   rec = 1'b0;
   always @(negedge clk) begin
      if (rec) begin
         dq.push_back(bus.dout);
         bq.push_back(bus.busy);
      end
   end

   logic [BITS-1:0] words[$];
   int npulses, badw, nleft, nbusy, bruns;

   task automatic start_rec();
      dq.delete();
      bq.delete();
      rec = 1'b1;
   endtask

   // Decode pulse widths into words; flag bad widths and broken in-word bit periods.
   task automatic analyze();
      int hi = 0, lo = 0, prevhi = 0, nb = 0;
      logic prev = 1'b0, pb = 1'b0, bv;
      logic [BITS-1:0] w = '0;
      words.delete();
      npulses = 0; badw = 0; nbusy = 0; bruns = 0;
      foreach (dq[i]) begin
         if (dq[i] === 1'b1) begin
            if (!prev) begin
               if (nb != 0 && lo != int'(TBIT) - prevhi) badw++;
               hi = 0;
            end
            hi++;
         end else begin
            if (prev) begin
               npulses++;
               bv = 1'b0;
               if (hi == int'(T1H)) bv = 1'b1;
               else if (hi != int'(T0H)) badw++;
               w = {w[BITS-2:0], bv};
               nb++;
               if (nb == int'(BITS)) begin
                  words.push_back(w);
                  nb = 0;
               end
               prevhi = hi;
               lo = 0;
            end
            lo++;
         end
         prev = (dq[i] === 1'b1);
      end
      foreach (bq[i]) begin
         if (bq[i] === 1'b1) begin
            nbusy++;
            if (!pb) bruns++;
         end
         pb = (bq[i] === 1'b1);
      end
      nleft = nb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      for (int w = 0; w < 3000 && bus.busy === 1'b1; w++) tick();
      chk(tag, bus.busy, 1'b0);
      repeat (2) tick();
   endtask

   logic [BITS-1:0] sent[$];
   logic [BITS-1:0] d;
   int first_rdy;
   bit got;

   initial begin
      bus.pixel_data  = '0;
      bus.pixel_valid = 1'b0;
      bus.latch_req   = 1'b0;

      // reset
      repeat (3) tick();
      chk("rst_dout", bus.dout, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst_ready", bus.pixel_ready, 1'b1);
      repeat (2) tick();

      // 1: single pixel 800000
      bus.pixel_data = 24'h800000; bus.pixel_valid = 1'b1; #1;
      chk("t1_ready", bus.pixel_ready, 1'b1);
      tick();
      bus.pixel_valid = 1'b0; bus.pixel_data = '0;
      start_rec();
      repeat (300) tick();
      rec = 1'b0;
      analyze();
      chk("t1_latency0", dq[0], 1'b0);
      chk("t1_latency1", dq[1], 1'b1);
      chk("t1_nwords", words.size(), 1);
      if (words.size() > 0) chk("t1_word", words[0], 24'h800000);
      chk("t1_pulses", npulses, 24);
      chk("t1_badw", badw, 0);
      chk("t1_busy", nbusy, 288);
      chk("t1_bruns", bruns, 1);
      chk("t1_tail", dq[dq.size()-1], 1'b0);
      wait_idle("t1_idle");

      // 2: back-to-back FFFFFF / 000000
      bus.pixel_data = 24'hFFFFFF; bus.pixel_valid = 1'b1;
      tick();
      start_rec();
      bus.pixel_data = 24'h000000;
      first_rdy = -1;
      for (int j = 0; j < 400; j++) begin
         if (bus.pixel_ready === 1'b1) begin
            first_rdy = j;
            tick();
            break;
         end
         tick();
      end
      bus.pixel_valid = 1'b0;
      chk("t2_accept_cycle", first_rdy, 287);
      repeat (330) tick();
      rec = 1'b0;
      analyze();
      chk("t2_nwords", words.size(), 2);
      if (words.size() > 1) begin
         chk("t2_word0", words[0], 24'hFFFFFF);
         chk("t2_word1", words[1], 24'h000000);
      end
      chk("t2_pulses", npulses, 48);
      chk("t2_badw", badw, 0);
      chk("t2_busy", nbusy, 576);
      chk("t2_bruns", bruns, 1);
      wait_idle("t2_idle");

      // 3a: latch request mid-pixel
      bus.pixel_data = 24'h123456; bus.pixel_valid = 1'b1;
      tick();
      bus.pixel_valid = 1'b0;
      start_rec();
      repeat (100) tick();
      bus.latch_req = 1'b1; tick(); bus.latch_req = 1'b0;
      repeat (720) tick();
      rec = 1'b0;
      analyze();
      chk("t3_nwords", words.size(), 1);
      if (words.size() > 0) chk("t3_word", words[0], 24'h123456);
      chk("t3_pulses", npulses, 24);
      chk("t3_busy", nbusy, 788);
      chk("t3_bruns", bruns, 1);
      wait_idle("t3_idle");

      // 3b: pending latch in IDLE blocks pixel_valid until the gap ends
      bus.latch_req = 1'b1; tick(); bus.latch_req = 1'b0;
      start_rec();
      bus.pixel_data = 24'h0F0F0F; bus.pixel_valid = 1'b1; #1;
      chk("t3_ready_blocked", bus.pixel_ready, 1'b0);
      first_rdy = -1;
      for (int j = 0; j < 700; j++) begin
         if (bus.pixel_ready === 1'b1) begin
            first_rdy = j;
            tick();
            break;
         end
         tick();
      end
      bus.pixel_valid = 1'b0;
      chk("t3_ready_after_gap", first_rdy, 501);
      repeat (300) tick();
      rec = 1'b0;
      analyze();
      chk("t3b_nwords", words.size(), 1);
      if (words.size() > 0) chk("t3b_word", words[0], 24'h0F0F0F);
      chk("t3b_busy", nbusy, 788);
      wait_idle("t3b_idle");

      // 4: merged pulses -> one gap; pulse during gap -> second gap back-to-back
      bus.pixel_data = 24'h5A5A5A; bus.pixel_valid = 1'b1;
      tick();
      bus.pixel_valid = 1'b0;
      start_rec();
      for (int j = 0; j < 1400; j++) begin
         bus.latch_req = (j == 50 || j == 150 || j == 388);
         tick();
      end
      bus.latch_req = 1'b0;
      rec = 1'b0;
      analyze();
      chk("t4_pulses", npulses, 24);
      chk("t4_busy", nbusy, 1288);
      chk("t4_bruns", bruns, 1);
      wait_idle("t4_idle");

      // 5: reset at bit 5 cnt 2, pending latch discarded
      bus.pixel_data = 24'hFFFFFF; bus.pixel_valid = 1'b1;
      tick();
      bus.pixel_valid = 1'b0;
      for (int j = 0; j < 62; j++) begin
         bus.latch_req = (j == 30);
         tick();
      end
      bus.latch_req = 1'b0;
      chk("t5_pre_dout", bus.dout, 1'b1);
      rst = 1'b1;
      tick();
      chk("t5_rst_dout", bus.dout, 1'b0);
      chk("t5_rst_busy", bus.busy, 1'b0);
      rst = 1'b0; #1;
      chk("t5_ready", bus.pixel_ready, 1'b1);
      bus.pixel_data = 24'hA5A5A5; bus.pixel_valid = 1'b1;
      tick();
      bus.pixel_valid = 1'b0;
      start_rec();
      repeat (320) tick();
      rec = 1'b0;
      analyze();
      chk("t5_nwords", words.size(), 1);
      if (words.size() > 0) chk("t5_word", words[0], 24'hA5A5A5);
      chk("t5_badw", badw, 0);
      chk("t5_busy", nbusy, 288);
      wait_idle("t5_idle");

      // 6: random pixels, gaps and latch pulses
      sent.delete();
      start_rec();
      for (int p = 0; p < 14; p++) begin
         int gap;
         bit lat;
         gap = $urandom_range(0, 12);
         lat = (gap > 1) && ($urandom_range(0, 3) == 0);
         for (int g = 0; g < gap; g++) begin
            bus.latch_req = lat && (g == 0);
            tick();
         end
         bus.latch_req = 1'b0;
         d = BITS'($urandom);
         bus.pixel_data = d; bus.pixel_valid = 1'b1; #1;
         got = 1'b0;
         for (int w = 0; w < 2000 && !got; w++) begin
            if (bus.pixel_ready === 1'b1) begin
               sent.push_back(d);
               got = 1'b1;
            end else begin
               d = BITS'($urandom);
               bus.pixel_data = d;
            end
            tick();
         end
         bus.pixel_valid = 1'b0;
         if (!got) chk("t6_accept_timeout", 32'd0, 32'd1);
      end
      for (int w = 0; w < 3000 && bus.busy === 1'b1; w++) tick();
      chk("t6_idle", bus.busy, 1'b0);
      repeat (3) tick();
      rec = 1'b0;
      analyze();
      chk("t6_nwords", words.size(), sent.size());
      chk("t6_badw", badw, 0);
      chk("t6_left", nleft, 0);
      for (int i = 0; i < sent.size() && i < words.size(); i++)
         chk("t6_word", words[i], sent[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
